// File: rtl/pov_column_sequencer.sv
// pov_column_sequencer
//   Drives the per-LED output latches of a POV display one column at a time,
//   locked to the rotor. The revolution period is measured between hall index
//   pulses, split into 2^COL_BITS equal columns, and for each column a pattern
//   word is fetched from the column RAM and presented with a one-clock load
//   strobe. The LEDs are blanked when rotation stops or the block is disabled.
//
// Ports
//   csi_clk      system clock
//   rsi_reset_n  asynchronous active-low reset
//   enable       display enable (synchronous)
//   hall_n       hall index sensor, asynchronous, active-low
//   mem_addr     column RAM read address (registered)
//   mem_rdata    column RAM data, valid one clock after mem_addr
//   led_data     column pattern to the LED latches (active-low pins)
//   led_control  one-clock load strobe to all LED latches
//   locked       revolution period is valid
//   rev_period   last accepted revolution period in clocks
module pov_column_sequencer #(
  parameter int LEDS       = 8,
  parameter int COL_BITS   = 7,
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1024
) (
  input  logic                csi_clk,
  input  logic                rsi_reset_n,
  input  logic                enable,
  input  logic                hall_n,
  output logic [COL_BITS-1:0] mem_addr,
  input  logic [LEDS-1:0]     mem_rdata,
  output logic [LEDS-1:0]     led_data,
  output logic                led_control,
  output logic                locked,
  output logic [CNT_W-1:0]    rev_period
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDX,
    FETCH,
    LOAD,
    HOLD,
    BLANK
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          hall_sync;
  logic                idx;
  logic [CNT_W-1:0]    per_cnt;
  logic                per_sat;
  logic                valid_idx;
  logic                interval_ok;
  logic                lock_set;
  logic                fault;
  logic                start;
  logic [CNT_W-1:0]    rev_nxt;
  logic [CNT_W-1:0]    col_period;
  logic [CNT_W-1:0]    col_tmr, col_tmr_nxt;
  logic [COL_BITS-1:0] col, col_nxt;
  logic [LEDS-1:0]     led_data_nxt;
  logic                led_control_nxt;

  // Two synchronizer flops, one history flop for the falling-edge detect and a
  // registered pulse: idx is high for one clock, three clocks after hall_n is
  // first sampled low.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      hall_sync <= '1;
      idx       <= 1'b0;
    end else begin
      hall_sync <= {hall_sync[1:0], hall_n};
      idx       <= hall_sync[2] & ~hall_sync[1];
    end
  end

  assign per_sat   = (per_cnt == '1);
  assign valid_idx = idx && (per_cnt >= CNT_W'(MIN_PERIOD));
  // interval_ok marks that per_cnt is timing an interval that started at a
  // valid index, so the first valid index after reset or a stall cannot lock.
  assign lock_set  = valid_idx & interval_ok & ~per_sat;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      per_cnt     <= '0;
      rev_period  <= '0;
      interval_ok <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (valid_idx) begin
        per_cnt    <= CNT_W'(1);
        rev_period <= per_cnt;
      end else if (!per_sat) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end

      if (valid_idx)
        interval_ok <= 1'b1;
      else if (per_sat)
        interval_ok <= 1'b0;

      if (!enable || per_sat)
        locked <= 1'b0;
      else if (lock_set)
        locked <= 1'b1;
    end
  end

  // The column timer reloads in the same clock that a valid index updates
  // rev_period, so it uses the incoming period rather than the stored one.
  assign rev_nxt    = valid_idx ? per_cnt : rev_period;
  assign col_period = rev_nxt >> COL_BITS;

  assign fault = ~enable | (locked & per_sat);
  assign start = valid_idx & (locked | lock_set);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state       <= IDLE;
      col         <= '0;
      col_tmr     <= '0;
      led_data    <= '1;
      led_control <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      col_tmr     <= col_tmr_nxt;
      led_data    <= led_data_nxt;
      led_control <= led_control_nxt;
    end
  end

  assign mem_addr = col;

  always_comb begin
    state_nxt       = state;
    col_nxt         = col;
    col_tmr_nxt     = (col_tmr != '0) ? col_tmr - CNT_W'(1) : col_tmr;
    led_data_nxt    = led_data;
    led_control_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable)
          state_nxt = WAIT_IDX;
      end

      WAIT_IDX: begin
        if (fault) begin
          state_nxt = BLANK;
        end else if (start) begin
          state_nxt   = FETCH;
          col_nxt     = '0;
          col_tmr_nxt = col_period - CNT_W'(1);
        end
      end

      FETCH, LOAD, HOLD: begin
        if (fault) begin
          state_nxt = BLANK;
        end else if (valid_idx) begin
          // Rotor sped up: restart at column 0, dropping any pending strobe.
          state_nxt   = FETCH;
          col_nxt     = '0;
          col_tmr_nxt = col_period - CNT_W'(1);
        end else if (state == FETCH) begin
          state_nxt = LOAD;
        end else if (state == LOAD) begin
          state_nxt       = HOLD;
          led_data_nxt    = mem_rdata;
          led_control_nxt = 1'b1;
        end else if (col_tmr == '0) begin
          if (col != '1) begin
            state_nxt   = FETCH;
            col_nxt     = col + COL_BITS'(1);
            col_tmr_nxt = col_period - CNT_W'(1);
          end else begin
            state_nxt = WAIT_IDX;
          end
        end
      end

      BLANK: begin
        led_data_nxt    = '1;
        led_control_nxt = 1'b1;
        state_nxt       = enable ? WAIT_IDX : IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pov_column_sequencer.sv
// tb_pov_column_sequencer
//   Directed bench for pov_column_sequencer (CNT_W=16, COL_BITS=7,
//   MIN_PERIOD=1024, LEDS=8). The column RAM holds RAM[a]=a. Stimulus pushes
//   each expected strobe (data and cycle) into a scoreboard; a monitor pops and
//   compares whenever led_control is high.
module tb_pov_column_sequencer;

  localparam int LEDS     = 8;
  localparam int COL_BITS = 7;
  localparam int CNT_W    = 16;
  localparam int MINP     = 1024;

  logic                csi_clk = 1'b0;
  logic                rsi_reset_n = 1'b0;
  logic                enable = 1'b0;
  logic                hall_n = 1'b1;
  logic [COL_BITS-1:0] mem_addr;
  logic [LEDS-1:0]     mem_rdata = '0;
  logic [LEDS-1:0]     led_data;
  logic                led_control;
  logic                locked;
  logic [CNT_W-1:0]    rev_period;

  pov_column_sequencer #(
    .LEDS(LEDS),
    .COL_BITS(COL_BITS),
    .CNT_W(CNT_W),
    .MIN_PERIOD(MINP)
  ) dut (
    .csi_clk(csi_clk),
    .rsi_reset_n(rsi_reset_n),
    .enable(enable),
    .hall_n(hall_n),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .led_data(led_data),
    .led_control(led_control),
    .locked(locked),
    .rev_period(rev_period)
  );

  always #5 csi_clk = ~csi_clk;

  int unsigned cyc = 0;
  always @(posedge csi_clk) cyc <= cyc + 1;

  // Column RAM with one clock read latency, RAM[a] = a.
  always @(posedge csi_clk) mem_rdata <= LEDS'(mem_addr);

  typedef struct {
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge csi_clk);
      if (rsi_reset_n && led_control) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL strobe: unexpected led_data=%02h at cycle %0d, want no strobe", led_data, cyc);
        end else begin
          e = sb.pop_front();
          if (led_data !== e.data || cyc != e.at) begin
            bad++;
            $display("FAIL strobe: got led_data=%02h at cycle %0d, want %02h at cycle %0d",
                     led_data, cyc, e.data, e.at);
          end
        end
      end
    end
  endtask

  // All waits run on the bench's own cycle counter, so they always end.
  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge csi_clk);
      #1;
    end
  endtask

  // hall_n driven low just after the edge that makes cyc == t.
  task automatic hall_at(input int unsigned t);
    wait_cyc(t);
    hall_n = 1'b0;
    wait_cyc(t + 8);
    hall_n = 1'b1;
  endtask

  // Index pulse at cycle k: first strobe at k+6, then one every cp clocks.
  task automatic push_rev(input int unsigned k, input int unsigned cp, input int unsigned ncols);
    for (int unsigned c = 0; c < ncols; c++)
      sb.push_back('{data: 8'(c), at: k + 6 + c * cp});
  endtask

  task automatic push_one(input logic [7:0] d, input int unsigned at);
    sb.push_back('{data: d, at: at});
  endtask

  int unsigned k0, k, k2, ka, kl, e, rbase;

  initial begin
    fork
      monitor();
    join_none

    // Reset values.
    repeat (3) @(posedge csi_clk);
    #1;
    check("rst led_control", 32'(led_control), 0);
    check("rst led_data", 32'(led_data), 32'hFF);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst locked", 32'(locked), 0);
    check("rst rev_period", 32'(rev_period), 0);
    rsi_reset_n = 1'b1;
    enable      = 1'b1;

    // First valid index only starts timing; second one locks.
    k0 = 1200;
    hall_at(k0);
    wait_cyc(k0 + 20);
    check("locked after 1st idx", 32'(locked), 0);
    k = k0 + 2560;
    push_rev(k, 20, 5);
    hall_at(k);
    wait_cyc(k + 20);
    check("locked after 2nd idx", 32'(locked), 1);
    check("rev_period 2560", 32'(rev_period), 2560);

    // Reset in the HOLD of column 4.
    wait_cyc(k + 95);
    check("mem_addr in col 4", 32'(mem_addr), 4);
    #2;
    rsi_reset_n = 1'b0;
    #1;
    check("midrst led_control", 32'(led_control), 0);
    check("midrst led_data", 32'(led_data), 32'hFF);
    check("midrst locked", 32'(locked), 0);
    check("midrst rev_period", 32'(rev_period), 0);
    check("midrst mem_addr", 32'(mem_addr), 0);
    wait_cyc(cyc + 3);
    rsi_reset_n = 1'b1;
    rbase = cyc;
    check("sb drained before reset", sb.size(), 0);

    // Relock, then a full revolution with a glitch 100 clocks after the index.
    k0 = rbase + 1200;
    hall_at(k0);
    k = k0 + 2560;
    push_rev(k, 20, 128);
    hall_at(k);
    hall_at(k + 100);
    wait_cyc(k + 120);
    check("rev_period after glitch", 32'(rev_period), 2560);
    check("locked after glitch", 32'(locked), 1);

    // Next index, rotor then speeds up: index lands in column 90.
    k = k + 2560;
    push_rev(k, 20, 91);
    hall_at(k);
    wait_cyc(k + 20);
    check("rev_period still 2560", 32'(rev_period), 2560);
    k2 = k + 1810;
    push_rev(k2, 14, 128);
    hall_at(k2);
    wait_cyc(k2 + 20);
    check("rev_period 1810", 32'(rev_period), 1810);

    // Enable dropped in the HOLD of column 9.
    ka = k2 + 1810;
    e  = ka + 137;
    push_rev(ka, 14, 10);
    push_one(8'hFF, e + 2);
    hall_at(ka);
    wait_cyc(e);
    enable = 1'b0;
    wait_cyc(e + 10);
    check("disabled mem_addr", 32'(mem_addr), 9);
    check("disabled locked", 32'(locked), 0);

    // Period still measured while disabled.
    hall_at(ka + 2000);
    wait_cyc(ka + 2020);
    check("rev_period while disabled", 32'(rev_period), 2000);
    check("idle mem_addr held", 32'(mem_addr), 9);
    check("idle locked", 32'(locked), 0);

    // Re-enable: next valid index relocks and runs; then the hall stops.
    enable = 1'b1;
    kl = ka + 4000;
    push_rev(kl, 15, 128);
    push_one(8'hFF, kl + 65540);
    hall_at(kl);
    wait_cyc(kl + 20);
    check("relocked", 32'(locked), 1);
    check("rev_period 2000", 32'(rev_period), 2000);
    wait_cyc(kl + 65560);
    check("locked after stall", 32'(locked), 0);
    check("rev_period after stall", 32'(rev_period), 2000);
    check("sb drained at end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
